// File: rtl/uart_tx_serializer.sv
// UART transmit engine: valid/ready front end into a small FIFO, then a framing FSM
// with runtime character length, parity, stop bits and baud divisor.
module uart_tx_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic [DATA_WIDTH-1:0]              tx_data,
    input  logic                               tx_valid,
    output logic                               tx_ready,
    input  logic [DIV_WIDTH-1:0]               baud_div,
    input  logic [3:0]                         char_len,
    input  logic [1:0]                         parity_mode,
    input  logic                               stop_bits,
    output logic                               tx,
    output logic                               busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count,
    output logic                               frame_done
);

    localparam int         PW      = $clog2(FIFO_DEPTH);
    localparam int         CW      = $clog2(FIFO_DEPTH + 1);
    localparam logic [3:0] MIN_LEN = 4'd5;
    localparam logic [3:0] MAX_LEN = 4'(DATA_WIDTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                 state;
    logic [DATA_WIDTH-1:0]  mem [FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr, rd_ptr;
    logic                   push, pop;
    logic [DATA_WIDTH-1:0]  shift;
    logic [DIV_WIDTH-1:0]   baud_cnt, b_lat, b_eff;
    logic [3:0]             bit_cnt, len_lat, len_eff;
    logic                   par_en, par_bit, stop2, head_par;
    logic                   wrap, last_stop, enter_stop, last_clk, pre_last;

    assign tx_ready = (fifo_count < CW'(FIFO_DEPTH));
    assign push     = tx_valid && tx_ready;
    assign pop      = (fifo_count != '0) && ((state == IDLE) || last_clk);

    // NOTE: every variable driven here gets a value on every path, so no latch is inferred.
    always_comb begin
        b_eff = (baud_div == '0) ? DIV_WIDTH'(1) : baud_div;
        if (char_len < MIN_LEN)      len_eff = MIN_LEN;
        else if (char_len > MAX_LEN) len_eff = MAX_LEN;
        else                         len_eff = char_len;
        head_par = 1'b0;
        for (int i = 0; i < DATA_WIDTH; i++)
            if (4'(i) < len_eff) head_par = head_par ^ mem[rd_ptr][i];
        if (parity_mode == 2'b10) head_par = ~head_par;
    end

    assign wrap       = (baud_cnt == b_lat - DIV_WIDTH'(1));
    assign last_stop  = (bit_cnt == {3'b000, stop2});
    assign last_clk   = (state == STOP) && wrap && last_stop;
    assign enter_stop = wrap && ((state == PARITY) ||
                        ((state == DATA) && (bit_cnt == len_lat - 4'd1) && !par_en));
    // frame_done is registered, so it is raised one clock ahead of the last STOP clock.
    assign pre_last   = ((state == STOP) && !wrap && last_stop && (baud_cnt == b_lat - DIV_WIDTH'(2)))
                     || ((state == STOP) && wrap && !last_stop && (b_lat == DIV_WIDTH'(1)))
                     || (enter_stop && !stop2 && (b_lat == DIV_WIDTH'(1)));

    // NOTE: the storage array carries no reset; validity is defined by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= tx_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            tx         <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            shift      <= '0;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            b_lat      <= DIV_WIDTH'(1);
            len_lat    <= MIN_LEN;
            par_en     <= 1'b0;
            par_bit    <= 1'b0;
            stop2      <= 1'b0;
        end else begin
            frame_done <= pre_last;
            baud_cnt   <= wrap ? '0 : baud_cnt + DIV_WIDTH'(1);
            case (state)
                IDLE: begin
                    tx       <= 1'b1;
                    busy     <= 1'b0;
                    baud_cnt <= '0;
                end
                START: if (wrap) begin
                    state <= DATA;
                    tx    <= shift[0];
                end
                DATA: if (wrap) begin
                    if (bit_cnt == len_lat - 4'd1) begin
                        bit_cnt <= '0;
                        state   <= par_en ? PARITY : STOP;
                        tx      <= par_en ? par_bit : 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                        shift   <= shift >> 1;
                        tx      <= shift[1];
                    end
                end
                PARITY: if (wrap) begin
                    state <= STOP;
                    tx    <= 1'b1;
                end
                STOP: if (wrap) begin
                    if (last_stop) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
            // NOTE: non-blocking assignments below win over those above in the same edge,
            // so a pop from IDLE or the last STOP clock overrides the case defaults.
            if (pop) begin
                state    <= START;
                tx       <= 1'b0;
                busy     <= 1'b1;
                shift    <= mem[rd_ptr];
                baud_cnt <= '0;
                bit_cnt  <= '0;
                b_lat    <= b_eff;
                len_lat  <= len_eff;
                par_en   <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
                par_bit  <= head_par;
                stop2    <= stop_bits;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench for uart_tx_serializer: stimulus queues expected frames, a negedge
// monitor reconstructs each frame on tx and compares it with a behavioural model.
module tb_uart_tx_serializer;

    localparam int DW   = 8;
    localparam int FD   = 4;
    localparam int DIVW = 16;

    logic                       clk = 1'b0;
    logic                       reset_n;
    logic [DW-1:0]              tx_data;
    logic                       tx_valid;
    logic                       tx_ready;
    logic [DIVW-1:0]            baud_div;
    logic [3:0]                 char_len;
    logic [1:0]                 parity_mode;
    logic                       stop_bits;
    logic                       tx;
    logic                       busy;
    logic [$clog2(FD+1)-1:0]    fifo_count;
    logic                       frame_done;

    uart_tx_serializer #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD), .DIV_WIDTH(DIVW)) dut (
        .clk(clk), .reset_n(reset_n), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .baud_div(baud_div), .char_len(char_len),
        .parity_mode(parity_mode), .stop_bits(stop_bits), .tx(tx), .busy(busy),
        .fifo_count(fifo_count), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        int         len;
        int         par;
        int         stop2;
        int         b;
    } rec_t;

    rec_t exp_q[$];
    int   start_cyc[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: frame described as a list of line levels, each held B clocks.
    function automatic int eff_len(input int cl);
        if (cl < 5) return 5;
        if (cl > DW) return DW;
        return cl;
    endfunction

    function automatic int eff_b(input int b);
        return (b == 0) ? 1 : b;
    endfunction

    function automatic int par_on(input rec_t r);
        return (r.par == 1 || r.par == 2) ? 1 : 0;
    endfunction

    function automatic int frame_clocks(input rec_t r);
        return eff_b(r.b) * (1 + eff_len(r.len) + par_on(r) + (r.stop2 != 0 ? 2 : 1));
    endfunction

    function automatic logic exp_tx(input rec_t r, input int idx);
        int slot = idx / eff_b(r.b);
        int len  = eff_len(r.len);
        int ones = 0;
        if (slot == 0) return 1'b0;
        if (slot <= len) return r.data[slot-1];
        if (par_on(r) == 1 && slot == len + 1) begin
            for (int i = 0; i < len; i++) ones += int'(r.data[i]);
            return (r.par == 1) ? logic'(ones % 2) : logic'(1 - ones % 2);
        end
        return 1'b1;
    endfunction

    // Monitor
    bit   mon_active = 0;
    bit   just_ended = 0;
    rec_t cur;
    int   mon_idx, mon_len, mis_cnt, first_mis, fd_cnt, fd_at, busy_bad;

    always @(negedge clk) begin
        if (!reset_n) begin
            mon_active = 0;
            just_ended = 0;
        end else begin
            if (!mon_active) begin
                if (tx === 1'b0) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_start", 1, 0);
                    end else begin
                        cur        = exp_q.pop_front();
                        mon_active = 1;
                        mon_idx    = 0;
                        mon_len    = frame_clocks(cur);
                        mis_cnt    = 0;
                        first_mis  = -1;
                        fd_cnt     = 0;
                        fd_at      = -1;
                        busy_bad   = 0;
                        start_cyc.push_back(cyc);
                    end
                end else if (just_ended) begin
                    check("busy_after_frame", int'(busy), 0);
                end else if (frame_done !== 1'b0) begin
                    check("stray_frame_done", int'(frame_done), 0);
                end
                just_ended = 0;
            end
            if (mon_active) begin
                if (tx !== exp_tx(cur, mon_idx)) begin
                    mis_cnt++;
                    if (first_mis < 0) first_mis = mon_idx;
                end
                if (frame_done === 1'b1) begin
                    fd_cnt++;
                    fd_at = mon_idx;
                end
                if (busy !== 1'b1) busy_bad = 1;
                mon_idx++;
                if (mon_idx == mon_len) begin
                    if (mis_cnt != 0)
                        $display("frame 0x%02h: first bad tx cycle %0d of %0d", cur.data, first_mis, mon_len);
                    check("frame_tx_bad_cycles", mis_cnt, 0);
                    check("frame_done_count", fd_cnt, 1);
                    check("frame_done_cycle", fd_at, mon_len - 1);
                    check("busy_in_frame", busy_bad, 0);
                    mon_active = 0;
                    just_ended = 1;
                end
            end
        end
    end

    task automatic set_cfg(input int b, input int len, input int par, input int stop2);
        baud_div    = DIVW'(b);
        char_len    = 4'(len);
        parity_mode = 2'(par);
        stop_bits   = (stop2 != 0);
    endtask

    function automatic rec_t make_rec(input logic [7:0] d);
        rec_t r;
        r.data  = d;
        r.len   = int'(char_len);
        r.par   = int'(parity_mode);
        r.stop2 = int'(stop_bits);
        r.b     = int'(baud_div);
        return r;
    endfunction

    task automatic push(input logic [7:0] d, output int acc_cyc);
        int guard = 0;
        while (!tx_ready && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        acc_cyc = -1;
        if (!tx_ready) begin
            check("push_ready_timeout", 0, 1);
        end else begin
            tx_data  = d;
            tx_valid = 1'b1;
            exp_q.push_back(make_rec(d));
            @(negedge clk);
            tx_valid = 1'b0;
            acc_cyc  = cyc;
        end
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while ((busy || fifo_count != 0 || mon_active || exp_q.size() != 0) && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("idle_within_budget", int'(n < limit), 1);
        @(negedge clk);
    endtask

    task automatic reset_now();
        reset_n = 1'b0;
        #1;
        check("rst_tx", int'(tx), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_fifo_count", int'(fifo_count), 0);
        check("rst_tx_ready", int'(tx_ready), 1);
        check("rst_frame_done", int'(frame_done), 0);
        exp_q.delete();
        start_cyc.delete();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, acc2, n_acc, n;
        logic [7:0] d;

        reset_n  = 1'b0;
        tx_data  = '0;
        tx_valid = 1'b0;
        set_cfg(4, 8, 0, 0);
        repeat (3) @(negedge clk);
        check("init_tx", int'(tx), 1);
        check("init_busy", int'(busy), 0);
        check("init_tx_ready", int'(tx_ready), 1);
        check("init_fifo_count", int'(fifo_count), 0);
        check("init_frame_done", int'(frame_done), 0);
        reset_n = 1'b1;
        @(negedge clk);

        // 8N1, B=4, 0xA5: start latency of one clock after the push edge
        start_cyc.delete();
        push(8'hA5, acc);
        wait_idle(200);
        check("t1_starts", start_cyc.size(), 1);
        if (start_cyc.size() > 0) check("t1_start_latency", start_cyc[0] - acc, 1);

        // 7 bits even parity, 0x55
        set_cfg(4, 7, 1, 0);
        push(8'h55, acc);
        wait_idle(200);

        // 8 bits odd parity two stop bits
        set_cfg(4, 8, 2, 1);
        push(8'h01, acc);
        push(8'h00, acc);
        wait_idle(400);

        // back-to-back frames: no idle gap between stop and next start
        set_cfg(4, 8, 0, 0);
        start_cyc.delete();
        push(8'h3C, acc);
        push(8'hC3, acc2);
        wait_idle(400);
        check("t5_starts", start_cyc.size(), 2);
        if (start_cyc.size() == 2) check("t5_start_gap", start_cyc[1] - start_cyc[0], 40);

        // FIFO fill with tx_valid held high at B=100
        set_cfg(100, 8, 0, 0);
        n_acc    = 0;
        tx_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (tx_ready) begin
                tx_data = 8'($urandom);
                exp_q.push_back(make_rec(tx_data));
                n_acc++;
            end
            @(negedge clk);
        end
        check("t4_accepted", n_acc, 5);
        check("t4_fifo_count_full", int'(fifo_count), 4);
        check("t4_tx_ready_full", int'(tx_ready), 0);
        tx_valid = 1'b0;
        n = 0;
        while (fifo_count == 4 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("t4_pop_seen", int'(n < 2000), 1);
        check("t4_fifo_count_after_pop", int'(fifo_count), 3);
        check("t4_tx_ready_after_pop", int'(tx_ready), 1);
        wait_idle(6000);

        // config change after the pop has no effect on the frame in flight
        set_cfg(3, 6, 2, 0);
        push(8'h2B, acc);
        repeat (3) @(negedge clk);
        set_cfg(1, 9, 1, 1);
        wait_idle(200);

        // reset mid-DATA, then normal operation; repeated with baud_div=0
        set_cfg(4, 8, 0, 0);
        push(8'h3C, acc);
        repeat (12) @(negedge clk);
        check("t6_busy_before_reset", int'(busy), 1);
        reset_now();
        push(8'h96, acc);
        wait_idle(200);

        set_cfg(0, 8, 1, 0);
        push(8'hF0, acc);
        push(8'h0F, acc);
        repeat (4) @(negedge clk);
        check("t6b_busy_before_reset", int'(busy), 1);
        reset_now();
        start_cyc.delete();
        push(8'h69, acc);
        push(8'h81, acc2);
        wait_idle(100);
        check("t6b_starts", start_cyc.size(), 2);
        if (start_cyc.size() == 2) check("t6b_start_gap", start_cyc[1] - start_cyc[0], 11);

        // randomized configs including out-of-range char_len and baud_div=0
        for (int k = 0; k < 10; k++) begin
            set_cfg($urandom_range(0, 6), $urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 1));
            n = $urandom_range(1, 5);
            for (int j = 0; j < n; j++) begin
                d = 8'($urandom);
                push(d, acc);
                if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 20)) @(negedge clk);
            end
            wait_idle(2000);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
